instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_ram.sv | 38 +++
 rtl/instruction_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout and control FSM states.
package instruction_fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: burst write of consecutive entries, wide combinational read.
module fetch_queue_ram
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned Depth   = 32,
  parameter int unsigned WrPorts = 8,
  parameter int unsigned RdPorts = 8
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic         [$clog2(Depth)-1:0] waddr_i,
  input  fetch_entry_t [WrPorts-1:0]     wdata_i,
  input  logic         [$clog2(Depth)-1:0] raddr_i,
  output fetch_entry_t [RdPorts-1:0]     rdata_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  fetch_entry_t mem_q [Depth];

  // Write WrPorts entries starting at waddr_i; the address sum wraps modulo Depth
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < WrPorts; k++) begin
        mem_q[waddr_i + AddrW'(k)] <= wdata_i[k];
      end
    end
  end

  // Read RdPorts consecutive entries starting at raddr_i, wrapping modulo Depth
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < RdPorts; i++) begin
      rdata_o[i] = mem_q[raddr_i + AddrW'(i)];
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: launches fixed-size fetches, buffers returned words with their PCs
// and presents the oldest entries to the issue controller. Redirects flush everything.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH     = 8,
  parameter int unsigned ISSUE_WIDTH     = 8,
  parameter int unsigned DEPTH           = 32,
  parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic [31:0]                          imem_addr,
  input  logic [FETCH_WIDTH-1:0][31:0]         imem_data,
  input  logic                                 redirect_valid,
  input  logic [31:0]                          redirect_pc,
  output logic [ISSUE_WIDTH-1:0]               deq_valid,
  output logic [ISSUE_WIDTH-1:0][31:0]         deq_instr,
  output logic [ISSUE_WIDTH-1:0][31:0]         deq_pc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     deq_count,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);

  localparam int unsigned PtrW       = $clog2(DEPTH);
  localparam int unsigned OccW       = $clog2(DEPTH+1);
  localparam int unsigned SumW       = OccW + 1;
  localparam logic [31:0] FetchBytes = 32'(4 * FETCH_WIDTH);

  ifq_state_e      state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;

  logic            launch;
  logic            ret_en;
  logic            flush_active;
  logic [SumW-1:0] committed;

  fetch_entry_t [FETCH_WIDTH-1:0] wdata;
  fetch_entry_t [ISSUE_WIDTH-1:0] rdata;

  // Launch only when the free space covers both the outstanding return and a new fetch
  always_comb begin
    committed = SumW'(occ_q) + (inflight_q ? SumW'(FETCH_WIDTH) : '0) + SumW'(FETCH_WIDTH);
    launch    = !redirect_valid && (committed <= SumW'(DEPTH));
    imem_addr = launch ? fetch_pc_q : addr_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a redirect (re)enters FLUSH, which otherwise lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   state_d = redirect_valid ? StFlush : StRun;
      StFlush: state_d = redirect_valid ? StFlush : StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    flush_active = (state_q == StFlush);
  end

  // Returned words are accepted only outside a flush and when no redirect is arriving
  always_comb begin
    ret_en = inflight_q && !flush_active && !redirect_valid;
  end

  // Tag each returned word with the byte PC of the fetch that produced it
  always_comb begin
    wdata = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wdata[k].instr = imem_data[k];
      wdata[k].pc    = addr_q + 32'(4 * k);
    end
  end

  // Pointer, occupancy and fetch-PC next state; a redirect overrides enqueue and dequeue
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = launch;
    fetch_pc_d = fetch_pc_q;
    addr_d     = imem_addr;
    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_pc;
    end else begin
      head_d = head_q + PtrW'(deq_count);
      if (ret_en) begin
        tail_d = tail_q + PtrW'(FETCH_WIDTH);
      end
      occ_d = occ_q + (ret_en ? OccW'(FETCH_WIDTH) : '0) - OccW'(deq_count);
      if (launch) begin
        fetch_pc_d = fetch_pc_q + FetchBytes;
      end
    end
  end

  // Queue control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      fetch_pc_q <= START_BYTE_ADDR;
      addr_q     <= START_BYTE_ADDR;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue_ram #(
    .Depth  (DEPTH),
    .WrPorts(FETCH_WIDTH),
    .RdPorts(ISSUE_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ret_en),
    .waddr_i(tail_q),
    .wdata_i(wdata),
    .raddr_i(head_q),
    .rdata_o(rdata)
  );

  // Present the head entries; slot i is valid while more than i entries are held
  always_comb begin
    deq_valid = '0;
    deq_instr = '0;
    deq_pc    = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      deq_valid[i] = (32'(occ_q) > 32'(i));
      deq_instr[i] = rdata[i].instr;
      deq_pc[i]    = rdata[i].pc;
    end
    occupancy = occ_q;
  end

  // Consuming more slots than are presented is a protocol violation by the issue controller
  deq_count_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    redirect_valid || ((32'(deq_count) <= 32'(occ_q)) && (32'(deq_count) <= ISSUE_WIDTH)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based model; a second ISSUE_WIDTH=4 instance is
// checked by an in-order delivery scoreboard.
module tb_instruction_fetch_queue;

  localparam int FW  = 8;
  localparam int IW  = 8;
  localparam int D   = 32;
  localparam int IW4 = 4;
  localparam logic [31:0] START = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ment_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (ISSUE_WIDTH = 8)
  logic                  rst_n;
  logic [31:0]           imem_addr;
  logic [FW-1:0][31:0]   imem_data;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [IW-1:0]         deq_valid;
  logic [IW-1:0][31:0]   deq_instr;
  logic [IW-1:0][31:0]   deq_pc;
  logic [3:0]            deq_count;
  logic [5:0]            occupancy;

  // Narrow-issue instance (ISSUE_WIDTH = 4)
  logic                  rst4_n;
  logic [31:0]           imem_addr4;
  logic [FW-1:0][31:0]   imem_data4;
  logic                  redirect_valid4;
  logic [31:0]           redirect_pc4;
  logic [IW4-1:0]        deq_valid4;
  logic [IW4-1:0][31:0]  deq_instr4;
  logic [IW4-1:0][31:0]  deq_pc4;
  logic [2:0]            deq_count4;
  logic [5:0]            occupancy4;

  instruction_fetch_queue #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(D), .START_BYTE_ADDR(START)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_count(deq_count), .occupancy(occupancy)
  );

  instruction_fetch_queue #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW4), .DEPTH(D), .START_BYTE_ADDR(START)
  ) dut4 (
    .clk(clk), .rst_n(rst4_n), .imem_addr(imem_addr4), .imem_data(imem_data4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .deq_valid(deq_valid4),
    .deq_instr(deq_instr4), .deq_pc(deq_pc4), .deq_count(deq_count4), .occupancy(occupancy4)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Instruction memory contents: a fixed scramble of the byte address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [FW-1:0][31:0] words_at(input logic [31:0] a);
    logic [FW-1:0][31:0] w;
    for (int k = 0; k < FW; k++) w[k] = word_of(a + 32'(4 * k));
    return w;
  endfunction

  // ---------------- behavioural model of the main instance ----------------
  ment_t       mq[$];
  bit          m_inflight;
  logic [31:0] m_inf_pc;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_last_addr;

  function automatic void model_reset();
    mq.delete();
    m_inflight  = 1'b0;
    m_inf_pc    = START;
    m_fetch_pc  = START;
    m_last_addr = START;
  endfunction

  function automatic bit m_launch();
    return !redirect_valid && ((D - mq.size() - (m_inflight ? FW : 0)) >= FW);
  endfunction

  // Advance the model across one clock edge using the inputs applied in the cycle just ended
  function automatic void model_edge();
    bit          l;
    logic [31:0] a;
    ment_t       e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    l = m_launch();
    a = l ? m_fetch_pc : m_last_addr;
    if (redirect_valid) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch_pc = redirect_pc;
    end else begin
      for (int k = 0; k < int'(deq_count); k++) void'(mq.pop_front());
      if (m_inflight) begin
        for (int k = 0; k < FW; k++) begin
          e.pc    = m_inf_pc + 32'(4 * k);
          e.instr = word_of(e.pc);
          mq.push_back(e);
        end
      end
      m_inflight = l;
      m_inf_pc   = a;
      if (l) m_fetch_pc = m_fetch_pc + 32'(4 * FW);
    end
    m_last_addr = a;
  endfunction

  bit          chk_en = 1'b0;
  logic [31:0] addr_s = START;

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin : cmp
    int n;
    n = mq.size();
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_launch() ? m_fetch_pc : m_last_addr);
      chk("occupancy", 32'(occupancy), 32'(n));
      chk("deq_valid", 32'(deq_valid), 32'((1 << ((n < IW) ? n : IW)) - 1));
      for (int i = 0; i < IW && i < n; i++) begin
        chk("deq_pc", deq_pc[i], mq[i].pc);
        chk("deq_instr", deq_instr[i], mq[i].instr);
      end
    end
    addr_s = imem_addr;
  end

  // ---------------- stimulus helpers ----------------
  bit fresh = 1'b0;

  task automatic advance();
    @(posedge clk);
    #1;
    model_edge();
    imem_data = words_at(addr_s);
  endtask

  // One cycle; dc < 0 picks a random legal deq_count, rv < 0 picks a random rare redirect
  task automatic cyc(input int rv, input logic [31:0] rpc, input int dc);
    int lim;
    if (!fresh) advance();
    fresh = 1'b0;
    lim = (mq.size() < IW) ? mq.size() : IW;
    if (rv < 0) begin
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = START + ($urandom_range(0, 4095) << 2);
    end else begin
      redirect_valid = rv[0];
      redirect_pc    = rpc;
    end
    deq_count = 4'((dc < 0) ? $urandom_range(0, lim) : dc);
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    fresh = 1'b1;
  endtask

  bit done4 = 1'b0;

  // ---------------- main directed + random sequence ----------------
  initial begin : drv
    logic [31:0] a_prev;
    model_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    deq_count = '0;
    imem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h3000);
    chk_en = 1'b1;
    release_reset();

    // Fill with no consumption: four fetches, then stall at full
    cyc(0, 0, 0); chk("fill_addr0", imem_addr, 32'h3000);
    cyc(0, 0, 0); chk("fill_addr1", imem_addr, 32'h3020);
    cyc(0, 0, 0); chk("fill_addr2", imem_addr, 32'h3040);
    cyc(0, 0, 0); chk("fill_addr3", imem_addr, 32'h3060);
    cyc(0, 0, 0); chk("stall_addr", imem_addr, 32'h3060);
    chk("stall_occ", 32'(occupancy), 32'd24);
    cyc(0, 0, 0); chk("full_occ", 32'(occupancy), 32'd32);
    chk("full_pc0", deq_pc[0], 32'h3000);
    chk("full_pc7", deq_pc[7], 32'h301C);

    // Full-rate drain: settles to one fetch per cycle across pointer wrap
    a_prev = imem_addr;
    for (int c = 0; c < 12; c++) begin
      a_prev = imem_addr;
      cyc(0, 0, 8);
    end
    chk("steady_occ", 32'(occupancy), 32'd16);
    chk("steady_stride", imem_addr - a_prev, 32'h20);

    // Redirect with a fetch in flight
    cyc(1, 32'h3400, 8);
    cyc(0, 0, 0); chk("redir_addr", imem_addr, 32'h3400);
    chk("redir_dv1", 32'(deq_valid), 32'd0);
    cyc(0, 0, 0); chk("redir_dv2", 32'(deq_valid), 32'd0);
    cyc(0, 0, 0); chk("redir_pc0", deq_pc[0], 32'h3400);
    chk("redir_dv3", 32'(deq_valid[0]), 32'd1);

    // Back-to-back redirects: last one wins
    cyc(1, 32'h3100, 0);
    cyc(1, 32'h3200, 0);
    cyc(0, 0, 0); chk("b2b_addr", imem_addr, 32'h3200);
    cyc(0, 0, 0); chk("b2b_dv", 32'(deq_valid), 32'd0);
    cyc(0, 0, 0); chk("b2b_pc0", deq_pc[0], 32'h3200);
    chk("b2b_pc7", deq_pc[7], 32'h321C);

    // Reach occupancy 20 with a fetch in flight, then reset mid-cycle
    repeat (6) cyc(0, 0, 0);
    chk("pre_rst_full", 32'(occupancy), 32'd32);
    cyc(0, 0, 8);
    cyc(0, 0, 4);
    cyc(0, 0, 0); chk("pre_rst_occ", 32'(occupancy), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_dv", 32'(deq_valid), 32'd0);
    chk("async_addr", imem_addr, 32'h3000);
    release_reset();
    cyc(0, 0, 0); chk("refetch_addr", imem_addr, 32'h3000);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("refetch_pc0", deq_pc[0], 32'h3000);

    // Random traffic with occasional redirects
    for (int c = 0; c < 3000; c++) cyc(-1, 0, -1);

    begin : wait4
      int guard;
      guard = 0;
      while (!done4 && guard < 3000) begin
        @(posedge clk);
        guard++;
      end
    end
    checks++;
    if (!done4) begin
      errors++;
      $display("FAIL iw4_timeout: narrow-issue run did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- ISSUE_WIDTH=4 scoreboard run ----------------
  initial begin : iw4
    logic [31:0] exp4_pc;
    logic [31:0] addr4_s;
    int          n4;
    int          dc4;
    int          delivered4;
    exp4_pc         = START;
    addr4_s         = START;
    delivered4      = 0;
    rst4_n          = 1'b0;
    redirect_valid4 = 1'b0;
    redirect_pc4    = '0;
    deq_count4      = '0;
    imem_data4      = '0;
    repeat (4) @(posedge clk);
    #1;
    rst4_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      imem_data4 = words_at(addr4_s);
      n4 = 0;
      for (int i = 0; i < IW4; i++) n4 += int'(deq_valid4[i]);
      dc4 = $urandom_range(0, n4);
      deq_count4 = 3'(dc4);
      @(negedge clk);
      for (int i = 0; i < dc4; i++) begin
        chk("iw4_pc", deq_pc4[i], exp4_pc);
        chk("iw4_instr", deq_instr4[i], word_of(exp4_pc));
        exp4_pc = exp4_pc + 32'd4;
        delivered4++;
      end
      checks++;
      if (occupancy4 > 6'd32) begin
        errors++;
        $display("FAIL iw4_overflow: occupancy %0d, limit 32", occupancy4);
      end
      addr4_s = imem_addr4;
    end
    checks++;
    if (delivered4 < 500) begin
      errors++;
      $display("FAIL iw4_progress: delivered %0d, required at least 500", delivered4);
    end
    done4 = 1'b1;
  end

endmodule
